// File: rtl/sound_arbiter.sv
// Grants the shared Sound engine to one of NUM_REQ note requesters (index 0 highest priority),
// latches that requester's note fields, and sequences start / play / silent gap with a watchdog.
module sound_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int OCTAVE_BITS    = 3,
    parameter int NOTE_BITS      = 4,
    parameter int LENGTH_BITS    = 4,
    parameter int GAP_CYCLES     = 100000,
    parameter int TIMEOUT_CYCLES = 2**27,
    parameter int PREEMPT        = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*OCTAVE_BITS-1:0]   req_octave,
    input  logic [NUM_REQ*NOTE_BITS-1:0]     req_note,
    input  logic [NUM_REQ*LENGTH_BITS-1:0]   req_length,
    output logic [NUM_REQ-1:0]               grant,
    output logic [NUM_REQ-1:0]               done,
    output logic [NUM_REQ-1:0]               aborted,
    output logic                             busy,
    output logic [$clog2(NUM_REQ)-1:0]       owner,
    output logic                             timeout_err,
    output logic                             snd_start,
    output logic                             snd_abort,
    output logic [OCTAVE_BITS-1:0]           snd_octave,
    output logic [NOTE_BITS-1:0]             snd_note,
    output logic [LENGTH_BITS-1:0]           snd_length,
    input  logic                             snd_over
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int GW = $clog2(GAP_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_PLAY, S_GAP} state_t;

    state_t                 state, state_d;
    logic [TW-1:0]          wdog, wdog_d;
    logic [GW-1:0]          gap_cnt, gap_d;
    logic [NUM_REQ-1:0]     grant_d, done_d, aborted_d;
    logic                   start_d, abort_d, terr_d, leave;
    logic [OW-1:0]          owner_d;
    logic [OCTAVE_BITS-1:0] oct_d;
    logic [NOTE_BITS-1:0]   note_d;
    logic [LENGTH_BITS-1:0] len_d;
    logic                   found, higher;
    int unsigned            pick_i;

    always_comb begin
        found  = 1'b0;
        pick_i = 0;
        higher = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req[i] && !found) begin
                found  = 1'b1;
                pick_i = i;
            end
            if (req[i] && (OW'(i) < owner))
                higher = 1'b1;
        end
    end

    always_comb begin
        state_d   = state;
        wdog_d    = wdog;
        gap_d     = gap_cnt;
        grant_d   = '0;
        done_d    = '0;
        aborted_d = '0;
        start_d   = 1'b0;
        abort_d   = 1'b0;
        terr_d    = timeout_err;
        owner_d   = owner;
        oct_d     = snd_octave;
        note_d    = snd_note;
        len_d     = snd_length;
        leave     = 1'b0;
        case (state)
            S_IDLE: begin
                if (found) begin
                    grant_d = NUM_REQ'(1) << pick_i;
                    owner_d = OW'(pick_i);
                    oct_d   = req_octave[pick_i*OCTAVE_BITS +: OCTAVE_BITS];
                    note_d  = req_note[pick_i*NOTE_BITS +: NOTE_BITS];
                    len_d   = req_length[pick_i*LENGTH_BITS +: LENGTH_BITS];
                    state_d = S_START;
                end
            end
            S_START: begin
                start_d = 1'b1;
                wdog_d  = '0;
                state_d = S_PLAY;
            end
            S_PLAY: begin
                wdog_d = wdog + TW'(1);
                // wdog==0 marks the first PLAY cycle, where a stale snd_over must be ignored
                if (wdog != '0) begin
                    if (snd_over) begin
                        done_d = NUM_REQ'(1) << owner;
                        leave  = 1'b1;
                    end else if ((PREEMPT != 0) && higher) begin
                        aborted_d = NUM_REQ'(1) << owner;
                        abort_d   = 1'b1;
                        leave     = 1'b1;
                    end else if (wdog == TW'(TIMEOUT_CYCLES - 1)) begin
                        aborted_d = NUM_REQ'(1) << owner;
                        abort_d   = 1'b1;
                        terr_d    = 1'b1;
                        leave     = 1'b1;
                    end
                end
                if (leave) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1))
                    state_d = S_IDLE;
                else
                    gap_d = gap_cnt + GW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wdog        <= '0;
            gap_cnt     <= '0;
            grant       <= '0;
            done        <= '0;
            aborted     <= '0;
            busy        <= 1'b0;
            owner       <= '0;
            timeout_err <= 1'b0;
            snd_start   <= 1'b0;
            snd_abort   <= 1'b0;
            snd_octave  <= '0;
            snd_note    <= '0;
            snd_length  <= '0;
        end else begin
            state       <= state_d;
            wdog        <= wdog_d;
            gap_cnt     <= gap_d;
            grant       <= grant_d;
            done        <= done_d;
            aborted     <= aborted_d;
            busy        <= (state_d != S_IDLE);
            owner       <= owner_d;
            timeout_err <= terr_d;
            snd_start   <= start_d;
            snd_abort   <= abort_d;
            snd_octave  <= oct_d;
            snd_note    <= note_d;
            snd_length  <= len_d;
        end
    end

endmodule

// File: tb/tb_sound_arbiter.sv
// Randomized scenario bench for sound_arbiter: each scenario is planned at the note level
// (grant/start/end cycles from the priority rules), then replayed; a monitor checks every pulse.
module tb_sound_arbiter;

    localparam int NR  = 3;
    localparam int OB  = 3;
    localparam int NB  = 4;
    localparam int LB  = 4;
    localparam int GAP = 4;
    localparam int TO  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*OB-1:0]  req_octave;
    logic [NR*NB-1:0]  req_note;
    logic [NR*LB-1:0]  req_length;
    logic [NR-1:0]     grant, done, aborted;
    logic              busy, timeout_err, snd_start, snd_abort, snd_over;
    logic [1:0]        owner;
    logic [OB-1:0]     snd_octave;
    logic [NB-1:0]     snd_note;
    logic [LB-1:0]     snd_length;

    always #5 clk = ~clk;

    sound_arbiter #(
        .NUM_REQ(NR), .OCTAVE_BITS(OB), .NOTE_BITS(NB), .LENGTH_BITS(LB),
        .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO), .PREEMPT(1)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_octave(req_octave), .req_note(req_note),
        .req_length(req_length), .grant(grant), .done(done), .aborted(aborted), .busy(busy),
        .owner(owner), .timeout_err(timeout_err), .snd_start(snd_start), .snd_abort(snd_abort),
        .snd_octave(snd_octave), .snd_note(snd_note), .snd_length(snd_length), .snd_over(snd_over)
    );

    typedef struct {
        int           c;
        logic [2:0]   g, d, a;
        logic         s, ab;
        logic [1:0]   own;
        logic [OB-1:0] oc;
        logic [NB-1:0] nt;
        logic [LB-1:0] ln;
        logic         te;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        mon_ev;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    int         t0;
    logic       m_terr = 1'b0;
    logic [OB-1:0] m_oc[NR];
    logic [NB-1:0] m_nt[NR];
    logic [LB-1:0] m_ln[NR];
    logic [2:0] s_set[1024];
    logic [2:0] s_clr[1024];
    bit         s_over[1024];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en && ((|grant) || (|done) || (|aborted) || snd_start || snd_abort)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d grant=%b done=%b aborted=%b start=%b abort=%b",
                         cyc, grant, done, aborted, snd_start, snd_abort);
            end else begin
                mon_ev = exp_q.pop_front();
                if (cyc != mon_ev.c || grant !== mon_ev.g || done !== mon_ev.d ||
                    aborted !== mon_ev.a || snd_start !== mon_ev.s || snd_abort !== mon_ev.ab ||
                    owner !== mon_ev.own || snd_octave !== mon_ev.oc || snd_note !== mon_ev.nt ||
                    snd_length !== mon_ev.ln || timeout_err !== mon_ev.te) begin
                    errors++;
                    $display("FAIL event got cyc=%0d g=%b d=%b a=%b st=%b ab=%b own=%0d f=%0d/%0d/%0d te=%b exp cyc=%0d g=%b d=%b a=%b st=%b ab=%b own=%0d f=%0d/%0d/%0d te=%b",
                             cyc, grant, done, aborted, snd_start, snd_abort, owner,
                             snd_octave, snd_note, snd_length, timeout_err,
                             mon_ev.c, mon_ev.g, mon_ev.d, mon_ev.a, mon_ev.s, mon_ev.ab, mon_ev.own,
                             mon_ev.oc, mon_ev.nt, mon_ev.ln, mon_ev.te);
                end
            end
        end
    end

    function automatic int lowest(input logic [2:0] m);
        for (int k = 0; k < 3; k++)
            if (m[k]) return k;
        return 0;
    endfunction

    task automatic push(input int off, input logic [2:0] g, input logic [2:0] d,
                        input logic [2:0] a, input logic s, input logic ab, input int i);
        ev_t ev;
        ev.c   = t0 + off;
        ev.g   = g;
        ev.d   = d;
        ev.a   = a;
        ev.s   = s;
        ev.ab  = ab;
        ev.own = 2'(i);
        ev.oc  = m_oc[i];
        ev.nt  = m_nt[i];
        ev.ln  = m_ln[i];
        ev.te  = m_terr;
        exp_q.push_back(ev);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({grant, done, aborted, snd_start, snd_abort, busy, owner, timeout_err,
             snd_octave, snd_note, snd_length} !== '0) begin
            errors++;
            $display("FAIL %s got grant=%b done=%b aborted=%b start=%b abort=%b busy=%b owner=%0d terr=%b f=%0d/%0d/%0d, required all 0",
                     name, grant, done, aborted, snd_start, snd_abort, busy, owner, timeout_err,
                     snd_octave, snd_note, snd_length);
        end
    endtask

    // force_out: -1 random, 0 timeout, 1 preempt (if possible), 3 normal done
    task automatic run_scenario(input int force_out, input bit do_reset, input bit force_stale,
                                input logic [2:0] force_mask);
        int t, p, e, i, j, r, notes, rst_off, end_off;
        bit grow;
        logic [2:0] pend;
        t0 = cyc + 1;
        for (int n = 0; n < 1024; n++) begin
            s_set[n] = '0; s_clr[n] = '0; s_over[n] = 1'b0;
        end
        for (int n = 0; n < NR; n++) begin
            m_oc[n] = OB'($urandom_range(0, 7));
            m_nt[n] = NB'($urandom_range(0, 15));
            m_ln[n] = LB'($urandom_range(0, 15));
        end
        req_octave = {m_oc[2], m_oc[1], m_oc[0]};
        req_note   = {m_nt[2], m_nt[1], m_nt[0]};
        req_length = {m_ln[2], m_ln[1], m_ln[0]};
        pend     = (force_mask != 0) ? force_mask : 3'($urandom_range(1, 7));
        s_set[0] = pend;
        t = 0; notes = 0; rst_off = -10; end_off = 0;
        while (pend != 0) begin
            i = lowest(pend);
            pend[i] = 1'b0;
            notes++;
            grow = (notes < 6);
            push(t + 1, 3'(1 << i), 3'b0, 3'b0, 1'b0, 1'b0, i);
            s_clr[t + 1] |= 3'(1 << i);
            p = t + 2;
            push(p, 3'b0, 3'b0, 3'b0, 1'b1, 1'b0, i);
            if (force_stale || $urandom_range(0, 1) == 1) s_over[p] = 1'b1;
            if (do_reset) begin
                rst_off = p + 3;
                pend = '0;
                t = p + 5;
                break;
            end
            if (grow && i < 2 && $urandom_range(0, 1) == 1) begin
                j = int'($urandom_range(i + 1, 2));
                if (!pend[j]) begin
                    s_set[p + 1] |= 3'(1 << j);
                    pend[j] = 1'b1;
                end
            end
            r = (force_out >= 0) ? force_out : int'($urandom_range(0, 5));
            if (r == 0) begin
                e = p + TO - 1;
                m_terr = 1'b1;
                push(e + 1, 3'b0, 3'b0, 3'(1 << i), 1'b0, 1'b1, i);
            end else if (r <= 2 && i > 0 && grow) begin
                j = int'($urandom_range(0, i - 1));
                e = p + int'($urandom_range(1, TO - 1));
                s_set[e] |= 3'(1 << j);
                pend[j] = 1'b1;
                push(e + 1, 3'b0, 3'b0, 3'(1 << i), 1'b0, 1'b1, i);
            end else begin
                e = p + int'($urandom_range(1, TO - 1));
                s_over[e] = 1'b1;
                if (grow && i > 0 && $urandom_range(0, 1) == 1) begin
                    j = int'($urandom_range(0, i - 1));
                    s_set[e] |= 3'(1 << j);
                    pend[j] = 1'b1;
                end
                push(e + 1, 3'b0, 3'(1 << i), 3'b0, 1'b0, 1'b0, i);
                if (grow && $urandom_range(0, 3) == 0) begin
                    s_set[e + 1] |= 3'(1 << i);
                    pend[i] = 1'b1;
                end
            end
            t = e + GAP + 1;
        end
        end_off = t;
        for (int c = 0; c <= end_off; c++) begin
            @(negedge clk);
            req      = (req & ~s_clr[c]) | s_set[c];
            snd_over = s_over[c];
            rst      = (c == rst_off);
            if (do_reset && c == rst_off + 1) begin
                m_terr = 1'b0;
                check_zero("reset_mid_play");
            end
            if (!do_reset && c == end_off) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_idle cyc=%0d got %b required 0", cyc, busy);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; snd_over = 1'b0;
        req_octave = '0; req_note = '0; req_length = '0;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        run_scenario(3, 1'b0, 1'b0, 3'b010);
        run_scenario(3, 1'b0, 1'b0, 3'b110);
        run_scenario(1, 1'b0, 1'b0, 3'b100);
        run_scenario(0, 1'b0, 1'b0, 3'b001);
        for (int n = 0; n < 30; n++) run_scenario(-1, 1'b0, 1'b0, 3'b000);
        run_scenario(3, 1'b1, 1'b0, 3'b100);
        run_scenario(3, 1'b0, 1'b1, 3'b001);
        run_scenario(0, 1'b0, 1'b1, 3'b010);
        for (int n = 0; n < 8; n++) run_scenario(-1, 1'b0, 1'b0, 3'b000);
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got %0d left required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
